// File: rtl/nx_axbs_mac_if.sv
// nx_axbs_mac_if: operand/result stream bundle for the multi-lane MAC.
// The slave modport is the MAC and the master modport is the stream source/sink.
// Lane i of in_a/in_b/out_data is the i-th element of each packed array.
interface nx_axbs_mac_if #(
    parameter int SIZE_A = 15,
    parameter int SIZE_B = 15,
    parameter int LANES  = 4,
    parameter int ACC_W  = 48
);
    logic                          in_valid;
    logic                          in_ready;
    logic [LANES-1:0][SIZE_A-1:0]  in_a;
    logic [LANES-1:0][SIZE_B-1:0]  in_b;
    logic                          in_first;
    logic                          in_last;
    logic                          out_valid;
    logic                          out_ready;
    logic [LANES-1:0][ACC_W-1:0]   out_data;
    logic [LANES-1:0]              out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_first, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_first, in_last, out_ready,
        output in_ready, out_valid, out_data, out_ovf
    );
endinterface

// File: rtl/nx_axbs_mac.sv
// nx_axbs_mac: LANES-wide signed multiply-accumulate.
// Each product is built from 7-bit chunks (top chunk signed 8-bit), then summed
// into a per-lane accumulator over first/last-delimited groups.
// Pipeline: S1 operands, S2 chunk products, S3 shift-add, S4 product,
// S5 accumulate, S6 output. One global enable freezes every stage on back-pressure.
// Build option NX_AXBS_MAC_SAT_EN: clamp the accumulator on overflow instead of wrapping.

module nx_axbs_mac_lane #(
    parameter int SIZE_A = 15,
    parameter int SIZE_B = 15,
    parameter int ACC_W  = 48
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_en,
    input  logic                     i_acc_en,
    input  logic                     i_first,
    input  logic                     i_out_en,
    input  logic [SIZE_A-1:0]        i_a,
    input  logic [SIZE_B-1:0]        i_b,
    output logic [ACC_W-1:0]         o_data,
    output logic                     o_ovf
);
    localparam int NCA = (SIZE_A + 5) / 7;   // chunks: low ones 7-bit unsigned, top one 8-bit signed
    localparam int NCB = (SIZE_B + 5) / 7;
    localparam int WA  = 7 * NCA + 1;
    localparam int WB  = 7 * NCB + 1;
    localparam int PW  = SIZE_A + SIZE_B;    // exact signed product width

    logic signed [SIZE_A-1:0] r_a;
    logic signed [SIZE_B-1:0] r_b;
    logic signed [WA-1:0]     w_ax;
    logic signed [WB-1:0]     w_bx;
    logic signed [17:0]       w_ca [NCA];
    logic signed [17:0]       w_cb [NCB];
    logic signed [17:0]       r_pp [NCA][NCB];
    logic signed [PW-1:0]     w_sum;
    logic signed [PW-1:0]     r_sum;
    logic signed [PW-1:0]     r_prod;
    logic signed [ACC_W-1:0]  r_acc;
    logic                     r_ovf;
    logic signed [ACC_W-1:0]  w_base;
    logic signed [ACC_W:0]    w_true;
    logic                     w_ovf;
    logic signed [ACC_W-1:0]  w_acc_nxt;
    logic [ACC_W-1:0]         r_out;
    logic                     r_out_ovf;

    assign w_ax = WA'(r_a);
    assign w_bx = WB'(r_b);

    for (genvar i = 0; i < NCA; i++) begin : g_ca
        if (i == NCA - 1) begin : g_top
            assign w_ca[i] = 18'($signed(w_ax[7*i+7 -: 8]));
        end else begin : g_low
            assign w_ca[i] = 18'(w_ax[7*i+6 -: 7]);
        end
    end

    for (genvar j = 0; j < NCB; j++) begin : g_cb
        if (j == NCB - 1) begin : g_top
            assign w_cb[j] = 18'($signed(w_bx[7*j+7 -: 8]));
        end else begin : g_low
            assign w_cb[j] = 18'(w_bx[7*j+6 -: 7]);
        end
    end

    // Shift-add of chunk products; arithmetic mod 2^PW is exact since the product fits PW.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < NCA; i++) begin
            for (int j = 0; j < NCB; j++) begin
                w_sum = w_sum + (PW'(r_pp[i][j]) <<< (7 * (i + j)));
            end
        end
    end

    // Accumulate one bit wider than ACC_W so the true sum's sign is known for ovf/clamp.
    always_comb begin
        w_base = i_first ? '0 : r_acc;
        w_true = (ACC_W+1)'(w_base) + (ACC_W+1)'(r_prod);
        w_ovf  = w_true[ACC_W] ^ w_true[ACC_W-1];
`ifdef NX_AXBS_MAC_SAT_EN
        if (!w_ovf)
            w_acc_nxt = w_true[ACC_W-1:0];
        else if (w_true[ACC_W])
            w_acc_nxt = {1'b1, {(ACC_W-1){1'b0}}};
        else
            w_acc_nxt = {1'b0, {(ACC_W-1){1'b1}}};
`else
        w_acc_nxt = w_true[ACC_W-1:0];
`endif
    end

    // Datapath stages S1..S4; they load whenever enabled, validity is tracked in the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_sum  <= '0;
            r_prod <= '0;
            for (int i = 0; i < NCA; i++)
                for (int j = 0; j < NCB; j++)
                    r_pp[i][j] <= '0;
        end else if (i_en) begin
            r_a    <= i_a;
            r_b    <= i_b;
            for (int i = 0; i < NCA; i++)
                for (int j = 0; j < NCB; j++)
                    r_pp[i][j] <= w_ca[i] * w_cb[j];
            r_sum  <= w_sum;
            r_prod <= r_sum;
        end
    end

    // S5 accumulator with sticky overflow, S6 result register loaded on a last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_ovf     <= 1'b0;
            r_out     <= '0;
            r_out_ovf <= 1'b0;
        end else begin
            if (i_acc_en) begin
                r_acc <= w_acc_nxt;
                r_ovf <= (r_ovf & ~i_first) | w_ovf;
            end
            if (i_out_en) begin
                r_out     <= r_acc;
                r_out_ovf <= r_ovf;
            end
        end
    end

    assign o_data = r_out;
    assign o_ovf  = r_out_ovf;
endmodule

module nx_axbs_mac #(
    parameter int SIZE_A = 15,
    parameter int SIZE_B = 15,
    parameter int LANES  = 4,
    parameter int ACC_W  = 48
) (
    input  logic          clk,
    input  logic          rst_n,
    nx_axbs_mac_if.slave  bus
);
    localparam int STAGES = 4;   // r_vld_pipe[0]=S1 ... r_vld_pipe[4]=S5

    logic                r_out_valid;
    logic                w_en;
    logic [STAGES:0]     r_vld_pipe;
    logic [STAGES:0]     r_last_pipe;
    logic [STAGES-1:0]   r_first_pipe;
    logic                w_acc_en;
    logic                w_out_en;

    // Any free or draining output slot lets the whole pipe advance.
    assign w_en          = !r_out_valid || bus.out_ready;
    assign bus.in_ready  = w_en;
    assign bus.out_valid = r_out_valid;
    assign w_acc_en      = w_en && r_vld_pipe[STAGES-1];
    assign w_out_en      = w_en && r_vld_pipe[STAGES] && r_last_pipe[STAGES];

    // Valid/flag shift registers and output valid; all frozen while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_pipe   <= '0;
            r_last_pipe  <= '0;
            r_first_pipe <= '0;
            r_out_valid  <= 1'b0;
        end else if (w_en) begin
            r_vld_pipe   <= {r_vld_pipe[STAGES-1:0], bus.in_valid};
            r_last_pipe  <= {r_last_pipe[STAGES-1:0], bus.in_last};
            r_first_pipe <= {r_first_pipe[STAGES-2:0], bus.in_first};
            r_out_valid  <= r_vld_pipe[STAGES] && r_last_pipe[STAGES];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        nx_axbs_mac_lane #(
            .SIZE_A (SIZE_A),
            .SIZE_B (SIZE_B),
            .ACC_W  (ACC_W)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_en     (w_en),
            .i_acc_en (w_acc_en),
            .i_first  (r_first_pipe[STAGES-1]),
            .i_out_en (w_out_en),
            .i_a      (bus.in_a[g]),
            .i_b      (bus.in_b[g]),
            .o_data   (bus.out_data[g]),
            .o_ovf    (bus.out_ovf[g])
        );
    end
endmodule

// File: doc/nx_axbs_mac.md
# nx_axbs_mac

Multi-lane signed multiply-accumulate engine built on the 7-bit-chunk AI-tensor decomposition used by the NPU's signed multiplier cores. It is the parametrised successor to the single fixed-latency multiplier core and adds four things: LANES parallel lanes, per-lane accumulation over first/last-delimited groups, valid/ready flow control with back-pressure, and overflow detection. It sits between operand streams and the vector reduction path in the MVU tiles.

## Interface
- SIZE_A, default 15: signed width of each lane's A operand (≥2).
- SIZE_B, default 15: signed width of each lane's B operand (≥2).
- LANES, default 4: number of independent MAC lanes.
- ACC_W, default 48: signed accumulator/result width. Must satisfy ACC_W ≥ SIZE_A+SIZE_B.
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_a  in  LANES*SIZE_A  lane i operand at [i*SIZE_A +: SIZE_A], signed.
- in_b  in  LANES*SIZE_B  lane i operand, signed.
- in_first  in  1  beat starts a new group; accumulator is cleared before adding.
- in_last  in  1  beat ends a group; result is emitted.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_data  out  LANES*ACC_W  lane i accumulated result, signed.
- out_ovf  out  LANES  lane i overflowed at least once during the group.

## Operation
- Products are exact signed a*b. Each operand is split into 7-bit unsigned chunks, and the top chunk is a signed 8-bit chunk. Partial products are chunk dot-products shifted by multiples of 7 and summed.
- The product is sign-extended to ACC_W. The accumulate rule is acc = (first ? 0 : acc) + product.
- A beat with first=1 and last=1 emits its single product.
- A beat without first after reset accumulates onto 0, because the reset value of acc is 0.
- Overflow: the true sum does not fit in signed ACC_W. When it occurs, the per-lane sticky ovf bit is set. The ovf bit is cleared by a first beat, which contributes only its own overflow.
- On a last beat, acc and ovf are loaded into the output register and out_valid is set.
- After a last beat, the accumulator is not cleared. A following beat without first continues from the emitted value.
- Pipeline enable: en = !out_valid || out_ready. in_ready = en. This is combinational from out_ready.
- All stages hold while en=0. No beat is dropped or duplicated.
- out_valid clears on a handshake unless a new last beat is loaded in the same cycle.
- Simultaneous load and consume (en=1 and a last beat at the accumulate stage): new data replaces old and out_valid stays 1.

## Timing
- Stages:
  - S1: operand and flag register.
  - S2: chunk products.
  - S3: shift-add tree.
  - S4: product register.
  - S5: accumulate.
  - S6: output register.
- Latency: out_valid rises 5 enabled clock edges after the accepting edge. With no stalls, this is 5 cycles.
- Throughput: one beat per cycle while out_ready=1, or while no result is pending.
- Stalls freeze every stage, valid bits included. Latency is counted in enabled edges only.
- Reset, asynchronous on falling rst_n, regardless of state, including mid-group or during a stall:
  - all stage valids cleared;
  - acc = 0, ovf = 0;
  - out_valid = 0, out_data = 0, out_ovf = 0;
  - in_ready = 1 while rst_n = 0 and after release.
- The first beat may be accepted on the first clk edge after rst_n deasserts.

## Configuration
- NX_AXBS_MAC_SAT_EN defined: on overflow, acc clamps to +(2^(ACC_W-1)-1) or -2^(ACC_W-1), following the sign of the true sum. Later beats accumulate from the clamped value.
- NX_AXBS_MAC_SAT_EN undefined: acc wraps modulo 2^ACC_W.
- ovf behaviour is identical in both builds.

## Test plan
- Single beat, SIZE 15/15, LANES=4, lane0 a=16383 b=-16384, first=last=1 -> 5 cycles later out_data lane0 = -268419072, ovf=0.
- Group of 8 beats, ACC_W=32, lane0 a=b=-16384 (product 2^28) -> after beat 7 acc=1879048192. The output is:
  - SAT build: 2147483647, ovf=1;
  - wrap build: -2147483648, ovf=1.
- Back-to-back stream of 20 single-beat groups with random operands and out_ready held low for 10 cycles -> in_ready drops the cycle out_valid is high and out_ready=0. All 20 results arrive in order, bit-exact against a reference model.
- Groups of 3 beats on all lanes, with a new group's first beat issued the cycle after the prior last beat -> no carry-over between groups; the ovf of the prior group does not leak.
- rst_n pulsed low for 1 cycle mid-group, with out_valid=1 pending -> out_valid=0 and out_data=0 immediately. A following first=last=1 beat a=3 b=-5 returns -15.
- Extreme operands a=-16384 b=-16384 and a=-16384 b=16383, single beats -> 268435456 and -268419072.
